trigger_chain_capture: RTL
==========================

// Module: trigger_chain_capture
// PURPOSE
//  Circular capture buffer directly downstream of the pre-trigger filter chain (LPF + 2 biquads).
//  Continuously records the filtered 8-sample/12-bit beats while armed and freezes after a trigger
//  plus a programmable post-trigger length, so filter output can be read back for inspection.
//  Single clock domain (aclk); the readback port is a simple registered RAM read.
// PARAMETERS
//  NSAMP   8    samples per beat
//  NBITS   12   bits per sample; beat width W = NSAMP*NBITS = 96
//  ADDR_W  9    buffer address width; DEPTH = 2**ADDR_W beats
// PORTS
//  aclk         in   1       clock; all logic on rising edge
//  aresetn      in   1       synchronous active-low reset
//  dat_i        in   W       filtered beat from trigger chain, new beat every cycle
//  arm_i        in   1       one-cycle pulse: start/restart capture
//  trig_i       in   1       one-cycle pulse: trigger event
//  posttrig_i   in   ADDR_W  beats to record after the trigger beat (sampled at trigger)
//  rd_addr_i    in   ADDR_W  readback address
//  rd_data_o    out  W       readback data, 1-cycle latency
//  state_o      out  2       00 IDLE, 01 ARMED, 10 POST, 11 DONE
//  done_o       out  1       high in DONE
//  wrapped_o    out  1       buffer written >= DEPTH beats since arm (full pre-trigger history valid)
//  trig_addr_o  out  ADDR_W  address holding the trigger-cycle beat
//  last_addr_o  out  ADDR_W  address of the last beat written
// BEHAVIOUR
//  Reset (aresetn=0 at edge): state IDLE, wr_ptr=0, done_o=0, wrapped_o=0, trig_addr_o=0,
//   last_addr_o=0, rd_data_o=0. RAM contents not cleared. Reset wins over all other inputs.
//  Write: in ARMED and POST, dat_i is written to mem[wr_ptr] every cycle, then wr_ptr+1 mod DEPTH.
//   last_addr_o tracks the written address. No writes in IDLE or DONE.
//  wrapped_o: set when wr_ptr wraps DEPTH-1 -> 0 while writing; cleared on accepted arm_i.
//  IDLE:  arm_i -> ARMED; wr_ptr=0, wrapped_o=0. trig_i ignored.
//  ARMED: trig_i -> POST; trig_addr_o=current wr_ptr (trigger-cycle beat is written);
//         post_cnt = min(posttrig_i, DEPTH-1). If post_cnt==0 the next state is DONE directly.
//         arm_i ignored. Trigger accepted regardless of wrapped_o.
//  POST:  writes continue; post_cnt decrements per write; the write with post_cnt==1 is the last,
//         then DONE. Exactly post_cnt beats follow the trigger beat. arm_i, trig_i ignored.
//  DONE:  done_o=1, buffer frozen, pointers held. arm_i -> ARMED (same actions as from IDLE);
//         trig_i ignored.
//  Simultaneous arm_i+trig_i: IDLE/DONE take the arm only (trig dropped); ARMED takes the trig.
//  Clip: posttrig_i >= DEPTH is impossible by width; DEPTH-1 clip ensures the trigger beat is never
//   overwritten. Pre-trigger beats available = wrapped_o ? DEPTH-1-post_cnt : trig_addr_o.
//  Readback: rd_data_o <= mem[rd_addr_i] every cycle, any state; read-first on same-address write.
//  Sample packing unchanged: sample k at bits [NBITS*k +: NBITS], no arithmetic on data.
//  state_o/done_o/addresses are registered (change the cycle after the causing edge).
// TESTING
//  1. Reset then idle 100 cycles with ramp dat_i -> state_o=00, no RAM writes, all outputs 0.
//  2. arm, 20 beats (beat n = {8{n[11:0]}}), trig, posttrig_i=5 -> trig_addr_o=20,
//     last_addr_o=25, DONE after 5 post beats, mem[20]=beat 20, mem[26] unwritten.
//  3. arm, 600 beats (DEPTH=512), trig, posttrig_i=0 -> wrapped_o=1, trig_addr_o=600 mod 512=88,
//     last_addr_o=88, DONE next cycle.
//  4. posttrig_i=511 with trigger at addr 10 -> writes stop at addr 9, mem[10] still trigger beat.
//  5. arm_i and trig_i same cycle from IDLE -> ARMED only; second trig -> POST; arm in POST ignored.
//  6. aresetn low mid-POST -> next cycle IDLE, done_o=0, pointers 0; readback of old data still valid.

Source files
------------

// File: rtl/trigger_chain_capture.sv
// Circular capture buffer for filtered beats: records while armed, freezes a
// programmable number of beats after the trigger, and offers a registered readback port.
module trigger_chain_capture #(
  parameter int NSAMP  = 8,
  parameter int NBITS  = 12,
  parameter int ADDR_W = 9
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NSAMP*NBITS-1:0]   dat_i,
  input  logic                     arm_i,
  input  logic                     trig_i,
  input  logic [ADDR_W-1:0]        posttrig_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  output logic [NSAMP*NBITS-1:0]   rd_data_o,
  output logic [1:0]               state_o,
  output logic                     done_o,
  output logic                     wrapped_o,
  output logic [ADDR_W-1:0]        trig_addr_o,
  output logic [ADDR_W-1:0]        last_addr_o
);

  localparam int W     = NSAMP * NBITS;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic                wrapped_q, wrapped_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic                done_q;
  logic [W-1:0]        rd_data_q;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   post_clip_s;

  logic [W-1:0]        mem [DEPTH];

  // posttrig_i is ADDR_W wide, so it never exceeds DEPTH-1 and the trigger beat survives.
  assign post_clip_s = posttrig_i;

  // Next-state, pointer and status computation.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    post_cnt_d  = post_cnt_q;
    wrapped_d   = wrapped_q;
    trig_addr_d = trig_addr_q;
    last_addr_d = last_addr_q;
    wr_en_s     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_i) begin
          state_d   = ST_ARMED;
          wr_ptr_d  = '0;
          wrapped_d = 1'b0;
        end else begin
          state_d   = state_q;
        end
      end
      ST_ARMED: begin
        wr_en_s = 1'b1;
        if (trig_i) begin
          trig_addr_d = wr_ptr_q;
          post_cnt_d  = post_clip_s;
          state_d     = (post_clip_s == '0) ? ST_DONE : ST_POST;
        end else begin
          state_d     = ST_ARMED;
        end
      end
      ST_POST: begin
        wr_en_s    = 1'b1;
        post_cnt_d = post_cnt_q - ADDR_W'(1);
        if (post_cnt_q == ADDR_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_POST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Write bookkeeping applies only in ARMED/POST, which never coincide with an accepted arm.
    if (wr_en_s) begin
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
      last_addr_d = wr_ptr_q;
      if (wr_ptr_q == {ADDR_W{1'b1}}) begin
        wrapped_d = 1'b1;
      end else begin
        wrapped_d = wrapped_d;
      end
    end else begin
      wr_ptr_d = wr_ptr_d;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      post_cnt_q  <= '0;
      wrapped_q   <= 1'b0;
      trig_addr_q <= '0;
      last_addr_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      post_cnt_q  <= post_cnt_d;
      wrapped_q   <= wrapped_d;
      trig_addr_q <= trig_addr_d;
      last_addr_q <= last_addr_d;
      done_q      <= (state_d == ST_DONE);
    end
  end

  // Capture RAM write port; contents survive reset, but reset suppresses the write.
  always_ff @(posedge aclk) begin
    if (aresetn && wr_en_s) begin
      mem[wr_ptr_q] <= dat_i;
    end
  end

  // Registered read port, read-first against a same-cycle write.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o   = rd_data_q;
  assign state_o     = state_q;
  assign done_o      = done_q;
  assign wrapped_o   = wrapped_q;
  assign trig_addr_o = trig_addr_q;
  assign last_addr_o = last_addr_q;

endmodule
